// File: rtl/data_mem_pkg.sv
// data_mem_pkg: access-size encodings, dump FSM states and alignment check for data_mem_banked
package data_mem_pkg;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
      return size == 2'b11 || (size == SZ_HALF && a[0]) || (size == SZ_WORD && a != 2'b00);
   endfunction
endpackage

// File: rtl/data_mem_banked_if.sv
// data_mem_banked_if: load/store bus plus end-of-run dump signals
interface data_mem_banked_if #(parameter int ADDR_W = 15);
   logic              MemWrite;
   logic              MemRead;
   logic [1:0]        Size;
   logic              Unsigned;
   logic [ADDR_W-1:0] Address;
   logic [31:0]       Write_data;
   logic [31:0]       Read_Data;
   logic              Misaligned;
   logic              eof;
   logic              busy;
   logic              dump_valid;
   logic [ADDR_W-3:0] dump_addr;
   logic [31:0]       dump_data;
   logic              dump_done;
   modport master (output MemWrite, MemRead, Size, Unsigned, Address, Write_data, eof,
                   input Read_Data, Misaligned, busy, dump_valid, dump_addr, dump_data, dump_done);
   modport slave (input MemWrite, MemRead, Size, Unsigned, Address, Write_data, eof,
                  output Read_Data, Misaligned, busy, dump_valid, dump_addr, dump_data, dump_done);
endinterface

// File: rtl/mem_load_align.sv
// mem_load_align: big-endian byte-lane selection for stores and loads, with load extension
module mem_load_align
   import data_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic        en,
   input  logic [31:0] wd,
   output logic [31:0] rdata,
   output logic [31:0] wdata,
   output logic [3:0]  wmask
);
   logic [7:0]  b;
   logic [15:0] h;
   assign b = 8'(word >> {~addr_lo, 3'b000});
   assign h = 16'(word >> {~addr_lo[1], 4'b0000});
   always_comb begin
      rdata = !en ? 32'h0 :
              size == SZ_BYTE ? {{24{~uns & b[7]}}, b} :
              size == SZ_HALF ? {{16{~uns & h[15]}}, h} : word;
      wdata = size == SZ_BYTE ? {4{wd[7:0]}} : size == SZ_HALF ? {2{wd[15:0]}} : wd;
      wmask = size == SZ_BYTE ? 4'b1000 >> addr_lo :
              size == SZ_HALF ? (addr_lo[1] ? 4'b0011 : 4'b1100) : 4'b1111;
   end
endmodule

// File: rtl/data_mem_banked.sv
// data_mem_banked: byte-lane data memory with combinational loads and an end-of-run dump of written words
module data_mem_banked
   import data_mem_pkg::*;
#(
   parameter int ADDR_W  = 15,
   parameter bit DUMP_EN = 1
) (
   input logic              clock,
   input logic              reset,
   data_mem_banked_if.slave bus
);
   localparam int IW    = ADDR_W - 2;
   localparam int DEPTH = 2 ** IW;
   logic [31:0]   mem [DEPTH];
   logic [IW-1:0] widx;
   logic [31:0]   wdata;
   logic [3:0]    wmask;
   logic          we;
   state_e        state;
   assign widx           = bus.Address[ADDR_W-1:2];
   assign bus.Misaligned = (bus.MemRead | bus.MemWrite) & misaligned(bus.Size, bus.Address[1:0]);
   assign we             = bus.MemWrite & ~bus.Misaligned & (state == IDLE);
   assign bus.busy       = state == SCAN;
   mem_load_align u_align (
      .word    (mem[widx]),
      .addr_lo (bus.Address[1:0]),
      .size    (bus.Size),
      .uns     (bus.Unsigned),
      .en      (bus.MemRead & ~bus.Misaligned),
      .wd      (bus.Write_data),
      .rdata   (bus.Read_Data),
      .wdata   (wdata),
      .wmask   (wmask)
   );
   // array is never reset; loads read the pre-edge contents
   always_ff @(posedge clock)
      if (we)
         for (int b = 0; b < 4; b++)
            if (wmask[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
   if (DUMP_EN) begin : g_dump
      logic [DEPTH-1:0] written;
      logic [IW-1:0]    idx;
      logic             eof_q;
      always_ff @(posedge clock)
         if (reset) begin
            state          <= IDLE;
            idx            <= '0;
            eof_q          <= 1'b0;
            written        <= '0;
            bus.dump_valid <= 1'b0;
            bus.dump_addr  <= '0;
            bus.dump_data  <= '0;
            bus.dump_done  <= 1'b0;
         end else begin
            eof_q <= bus.eof;
            if (we) written[widx] <= 1'b1;
            case (state)
               IDLE: if (bus.eof && !eof_q) begin
                  state <= SCAN;
                  idx   <= '0;
               end
               SCAN: begin
                  bus.dump_valid <= written[idx];
                  bus.dump_addr  <= idx;
                  bus.dump_data  <= mem[idx];
                  idx            <= idx + 1'b1;
                  if (&idx) state <= DONE;
               end
               DONE: begin
                  bus.dump_valid <= 1'b0;
                  bus.dump_done  <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
   end else begin : g_no_dump
      assign state          = IDLE;
      assign bus.dump_valid = 1'b0;
      assign bus.dump_addr  = '0;
      assign bus.dump_data  = '0;
      assign bus.dump_done  = 1'b0;
   end
endmodule

// File: tb/tb_data_mem_banked.sv
// tb_data_mem_banked: vector table for load/store alignment plus scoreboarded dump sequences
module tb_data_mem_banked;
   import data_mem_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   always #5 clk = ~clk;
   data_mem_banked_if #(.ADDR_W(6)) bus ();
   data_mem_banked #(.ADDR_W(6), .DUMP_EN(1)) dut (.clock(clk), .reset(rst), .bus(bus));
   typedef struct {
      logic        wr;
      logic        rd;
      logic [1:0]  sz;
      logic        uns;
      logic [5:0]  a;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_mis;
   } vec_t;
   typedef struct packed {
      logic [3:0]  a;
      logic [31:0] d;
   } dexp_t;
   vec_t  tbl[$];
   dexp_t sb[$];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic drive(input logic wr, input logic rd, input logic [1:0] sz, input logic uns,
                        input logic [5:0] a, input logic [31:0] wd);
      bus.MemWrite = wr;
      bus.MemRead = rd;
      bus.Size = sz;
      bus.Unsigned = uns;
      bus.Address = a;
      bus.Write_data = wd;
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic store(input logic [5:0] a, input logic [31:0] wd);
      drive(1, 0, SZ_WORD, 0, a, wd);
      step();
      drive(0, 0, SZ_WORD, 0, a, 0);
   endtask
   task automatic load_chk(input string nm, input logic [5:0] a, input logic [31:0] exp);
      drive(0, 1, SZ_WORD, 0, a, 0);
      #1;
      chk(nm, bus.Read_Data, exp);
      drive(0, 0, SZ_WORD, 0, a, 0);
   endtask
   task automatic reset_pulse();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask
   // raises eof, then samples every edge; stops at dump_done, the cycle bound, or abort_n
   task automatic dump_run(input int abort_n, input bit probe, output int n, output int bc);
      dexp_t e;
      n = 0;
      bc = 0;
      bus.eof = 1'b1;
      step();
      bus.MemWrite = 1'b0;
      forever begin
         if (bus.busy) bc++;
         if (bus.dump_valid) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected dump: got addr %0d data %h expected none", bus.dump_addr, bus.dump_data);
            end else begin
               e = sb.pop_front();
               chk("dump_addr", 32'(bus.dump_addr), 32'(e.a));
               chk("dump_data", bus.dump_data, e.d);
            end
         end
         if (bus.dump_done || n >= 40 || n == abort_n) break;
         if (probe && n == 3) begin
            drive(1, 1, SZ_WORD, 0, 6'h14, 32'hDEADBEEF);
            #1;
            chk("scan load", bus.Read_Data, 32'h000055AA);
         end
         step();
         if (probe && n == 3) drive(0, 0, SZ_WORD, 0, 0, 0);
         n++;
      end
      bus.eof = 1'b0;
   endtask
   initial begin
      int n;
      int bc;
      int vc;
      int dc;
      bus.eof = 1'b0;
      drive(0, 0, SZ_WORD, 0, 0, 0);
      tbl.push_back('{1, 0, SZ_WORD, 0, 6'h10, 32'h800000F0, 32'h0, 0});
      tbl.push_back('{0, 1, SZ_BYTE, 0, 6'h13, 32'h0, 32'hFFFFFFF0, 0});
      tbl.push_back('{0, 1, SZ_BYTE, 1, 6'h13, 32'h0, 32'h000000F0, 0});
      tbl.push_back('{0, 1, SZ_HALF, 0, 6'h10, 32'h0, 32'hFFFF8000, 0});
      tbl.push_back('{0, 1, SZ_HALF, 1, 6'h10, 32'h0, 32'h00008000, 0});
      tbl.push_back('{0, 1, SZ_BYTE, 0, 6'h10, 32'h0, 32'hFFFFFF80, 0});
      tbl.push_back('{1, 0, SZ_BYTE, 0, 6'h12, 32'h0000007F, 32'h0, 0});
      tbl.push_back('{0, 1, SZ_WORD, 0, 6'h10, 32'h0, 32'h80007FF0, 0});
      tbl.push_back('{1, 0, SZ_WORD, 0, 6'h04, 32'hCAFEF00D, 32'h0, 0});
      tbl.push_back('{1, 0, SZ_WORD, 0, 6'h06, 32'h12345678, 32'h0, 1});
      tbl.push_back('{0, 1, SZ_WORD, 0, 6'h04, 32'h0, 32'hCAFEF00D, 0});
      tbl.push_back('{0, 1, SZ_HALF, 0, 6'h05, 32'h0, 32'h0, 1});
      tbl.push_back('{0, 1, SZ_WORD, 0, 6'h11, 32'h0, 32'h0, 1});
      tbl.push_back('{0, 1, SZ_WORD, 0, 6'h12, 32'h0, 32'h0, 1});
      tbl.push_back('{0, 1, 2'b11, 0, 6'h10, 32'h0, 32'h0, 1});
      tbl.push_back('{1, 0, 2'b11, 0, 6'h10, 32'hFFFFFFFF, 32'h0, 1});
      tbl.push_back('{0, 0, SZ_WORD, 0, 6'h10, 32'h0, 32'h0, 0});
      tbl.push_back('{0, 0, SZ_HALF, 0, 6'h05, 32'h0, 32'h0, 0});
      tbl.push_back('{1, 0, SZ_HALF, 0, 6'h12, 32'h0000BEEF, 32'h0, 0});
      tbl.push_back('{0, 1, SZ_HALF, 1, 6'h12, 32'h0, 32'h0000BEEF, 0});
      tbl.push_back('{0, 1, SZ_HALF, 0, 6'h12, 32'h0, 32'hFFFFBEEF, 0});
      tbl.push_back('{0, 1, SZ_WORD, 0, 6'h10, 32'h0, 32'h8000BEEF, 0});
      tbl.push_back('{1, 1, SZ_WORD, 0, 6'h10, 32'h11223344, 32'h8000BEEF, 0});
      tbl.push_back('{0, 1, SZ_WORD, 0, 6'h10, 32'h0, 32'h11223344, 0});
      tbl.push_back('{0, 1, SZ_BYTE, 1, 6'h11, 32'h0, 32'h00000022, 0});
      tbl.push_back('{0, 1, SZ_BYTE, 0, 6'h12, 32'h0, 32'h00000033, 0});
      tbl.push_back('{1, 0, SZ_BYTE, 0, 6'h17, 32'h000000A5, 32'h0, 0});
      tbl.push_back('{0, 1, SZ_BYTE, 1, 6'h17, 32'h0, 32'h000000A5, 0});
      tbl.push_back('{0, 1, SZ_BYTE, 0, 6'h17, 32'h0, 32'hFFFFFFA5, 0});
      step();
      step();
      chk("rst busy", 32'(bus.busy), 0);
      chk("rst dump_valid", 32'(bus.dump_valid), 0);
      chk("rst dump_addr", 32'(bus.dump_addr), 0);
      chk("rst dump_data", bus.dump_data, 0);
      chk("rst dump_done", 32'(bus.dump_done), 0);
      rst = 1'b0;
      foreach (tbl[i]) begin
         drive(tbl[i].wr, tbl[i].rd, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd);
         #3;
         chk($sformatf("vec%0d rd", i), bus.Read_Data, tbl[i].exp_rd);
         chk($sformatf("vec%0d mis", i), 32'(bus.Misaligned), 32'(tbl[i].exp_mis));
         step();
      end
      drive(0, 0, SZ_WORD, 0, 0, 0);
      reset_pulse();
      load_chk("mem kept over reset", 6'h10, 32'h11223344);
      drive(1, 0, SZ_WORD, 0, 6'h06, 32'h12345678);
      #1;
      chk("misaligned sw", 32'(bus.Misaligned), 1);
      step();
      store(6'h0C, 32'hA);
      sb.push_back('{4'd3, 32'hA});
      store(6'h24, 32'hB);
      sb.push_back('{4'd9, 32'hB});
      step();
      dump_run(-1, 0, n, bc);
      chk("done edges", 32'(n), 17);
      chk("busy cycles", 32'(bc), 16);
      chk("dumps missing", 32'(sb.size()), 0);
      chk("done valid", 32'(bus.dump_valid), 0);
      chk("done busy", 32'(bus.busy), 0);
      store(6'h0C, 32'hFF);
      bus.eof = 1'b1;
      vc = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus.dump_valid || bus.busy || !bus.dump_done) vc++;
      end
      bus.eof = 1'b0;
      chk("eof in done", 32'(vc), 0);
      load_chk("store in done", 6'h0C, 32'hA);
      reset_pulse();
      drive(1, 0, SZ_WORD, 0, 6'h14, 32'h000055AA);
      sb.push_back('{4'd5, 32'h000055AA});
      dump_run(-1, 1, n, bc);
      chk("eof store edges", 32'(n), 17);
      chk("eof store dumps", 32'(sb.size()), 0);
      load_chk("scan store dropped", 6'h14, 32'h000055AA);
      reset_pulse();
      store(6'h0C, 32'h3);
      sb.push_back('{4'd3, 32'h3});
      store(6'h14, 32'h5);
      sb.push_back('{4'd5, 32'h5});
      store(6'h30, 32'hC);
      step();
      dump_run(8, 0, n, bc);
      chk("abort index", 32'(n), 8);
      chk("abort dumps", 32'(sb.size()), 0);
      reset_pulse();
      vc = 0;
      dc = 0;
      for (int i = 0; i < 24; i++) begin
         if (bus.dump_valid) vc++;
         if (bus.dump_done || bus.busy) dc++;
         step();
      end
      chk("after abort valid", 32'(vc), 0);
      chk("after abort done", 32'(dc), 0);
      dump_run(-1, 0, n, bc);
      chk("restart edges", 32'(n), 17);
      chk("restart busy", 32'(bc), 16);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
